drop_in_multi_hole: RTL

- Successor to the single-hole drop detector: checks the ball against N_HOLES holes with one shared squared-distance datapath, scanning one hole per cycle.
- Debounces a hit over DWELL consecutive scans and reports which hole captured the ball.
- Flags whether the captured hole is the goal hole (win) or a trap (fall).
- Sits between the ball-physics block and the game-state FSM.

---
 rtl/teeter_pkg.sv | 25 ++
 rtl/drop_in_multi_hole_if.sv | 31 +++
 rtl/drop_in_multi_hole_hole_dist_sq.sv | 82 ++++++++
 rtl/drop_in_multi_hole.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/teeter_pkg.sv
// Shared types and constants for the teeter ball/hole logic.
// Coordinate width, FSM state encoding and the capture-radius sizing helper.
package teeter_pkg;

  localparam int COORD_W = 10;
  localparam int SQ_W    = 2 * COORD_W + 1;
  localparam int DWELL_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    CAPTURED
  } scan_state_t;

  // Bits needed to hold radius*radius (at least 1).
  function automatic int rsq_width(input int radius);
    int rsq;
    int w;
    rsq = radius * radius;
    w   = 1;
    while ((rsq >> w) != 0) w++;
    return w;
  endfunction

endpackage

// File: rtl/drop_in_multi_hole_if.sv
// Ball/hole inputs and capture outputs of the multi-hole drop detector.
// The physics side drives the master modport; the detector takes the slave modport.
interface drop_in_multi_hole_if #(
  parameter int N_HOLES = 8,
  parameter int IDX_W   = 4
);
  import teeter_pkg::*;

  logic                       is_game_playing;
  logic                       i_clear;
  logic [COORD_W-1:0]         i_bl_x;
  logic [COORD_W-1:0]         i_bl_y;
  logic [COORD_W*N_HOLES-1:0] i_holes_x;
  logic [COORD_W*N_HOLES-1:0] i_holes_y;
  logic [N_HOLES-1:0]         i_hole_en;
  logic                       o_fall_in;
  logic                       o_win;
  logic [IDX_W-1:0]           o_hole_idx;
  logic                       o_scan_done;

  modport master (
    output is_game_playing, i_clear, i_bl_x, i_bl_y, i_holes_x, i_holes_y, i_hole_en,
    input  o_fall_in, o_win, o_hole_idx, o_scan_done
  );

  modport slave (
    input  is_game_playing, i_clear, i_bl_x, i_bl_y, i_holes_x, i_holes_y, i_hole_en,
    output o_fall_in, o_win, o_hole_idx, o_scan_done
  );

endinterface

// File: rtl/drop_in_multi_hole_hole_dist_sq.sv
// Point-in-circle test: |dx|,|dy| then dx^2+dy^2 <= RADIUS^2, 2-cycle latency.
// No backpressure; i_flush kills both stages' valids so in-flight results are dropped.
module hole_dist_sq
  import teeter_pkg::*;
#(
  parameter int RADIUS = 16,
  parameter int IDX_W  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic               i_vld,
  input  logic [IDX_W-1:0]   i_idx,
  input  logic               i_en,
  input  logic [COORD_W-1:0] i_ax,
  input  logic [COORD_W-1:0] i_ay,
  input  logic [COORD_W-1:0] i_bx,
  input  logic [COORD_W-1:0] i_by,
  output logic               o_vld,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_hit
);

  localparam int RSQ_W = rsq_width(RADIUS);
  localparam int CMP_W = (RSQ_W > SQ_W) ? RSQ_W : SQ_W;
  localparam logic [CMP_W-1:0] RSQ = CMP_W'(RADIUS * RADIUS);

  // Signed 11-bit subtract so a < b yields the true distance, not a wrapped one.
  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    logic signed [COORD_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[COORD_W] ? COORD_W'(-d) : COORD_W'(d);
  endfunction

  logic               s1_vld;
  logic               s1_en;
  logic [IDX_W-1:0]   s1_idx;
  logic [COORD_W-1:0] s1_dx;
  logic [COORD_W-1:0] s1_dy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_vld <= 1'b0;
      s1_en  <= 1'b0;
      s1_idx <= '0;
      s1_dx  <= '0;
      s1_dy  <= '0;
    end else begin
      s1_vld <= i_vld & ~i_flush;
      s1_en  <= i_en;
      s1_idx <= i_idx;
      s1_dx  <= abs_diff(i_ax, i_bx);
      s1_dy  <= abs_diff(i_ay, i_by);
    end
  end

  logic [2*COORD_W-1:0] dx2;
  logic [2*COORD_W-1:0] dy2;
  logic [SQ_W-1:0]      sq;
  logic                 in_radius;

  always_comb begin
    dx2       = {{COORD_W{1'b0}}, s1_dx} * {{COORD_W{1'b0}}, s1_dx};
    dy2       = {{COORD_W{1'b0}}, s1_dy} * {{COORD_W{1'b0}}, s1_dy};
    sq        = {1'b0, dx2} + {1'b0, dy2};
    in_radius = (CMP_W'(sq) <= RSQ);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_vld <= 1'b0;
      o_idx <= '0;
      o_hit <= 1'b0;
    end else begin
      o_vld <= s1_vld & ~i_flush;
      o_idx <= s1_idx;
      o_hit <= s1_en & in_radius;
    end
  end

endmodule

// File: rtl/drop_in_multi_hole.sv
// Scans N_HOLES holes one per cycle (N_HOLES+2 cycles per scan), debounces over DWELL scans.
// No backpressure; capture is sticky until i_clear, and dropping is_game_playing aborts a scan.
module drop_in_multi_hole
  import teeter_pkg::*;
#(
  parameter int N_HOLES  = 8,
  parameter int RADIUS   = 16,
  parameter int DWELL    = 2,
  parameter int GOAL_IDX = 0,
  parameter int IDX_W    = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  drop_in_multi_hole_if.slave bus
);

  localparam int CNT_W = $clog2(N_HOLES + 2);
  localparam logic [CNT_W-1:0] ISSUE_END = CNT_W'(N_HOLES);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(N_HOLES + 1);

  scan_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] snap_x_q, snap_x_d;
  logic [COORD_W-1:0] snap_y_q, snap_y_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [IDX_W-1:0]   cand_q, cand_d;
  logic               best_vld_q, best_vld_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic               fall_q, fall_d;
  logic               win_q, win_d;
  logic [IDX_W-1:0]   hole_idx_q, hole_idx_d;
  logic               scan_done_q, scan_done_d;

  logic               issue_vld;
  logic               flush;
  logic               take_snap;
  logic [IDX_W-1:0]   issue_idx;
  logic [COORD_W-1:0] hole_x;
  logic [COORD_W-1:0] hole_y;
  logic               hole_en;
  logic               res_vld;
  logic [IDX_W-1:0]   res_idx;
  logic               res_hit;
  logic               scan_hit;
  logic [IDX_W-1:0]   scan_idx;
  logic [DWELL_W-1:0] dwell_nx;
  logic [IDX_W-1:0]   cand_nx;
  logic               goal_nx;

  assign issue_idx = IDX_W'(cnt_q);

  always_comb begin
    hole_x  = '0;
    hole_y  = '0;
    hole_en = 1'b0;
    for (int h = 0; h < N_HOLES; h++) begin
      if (issue_idx == IDX_W'(h)) begin
        hole_x  = bus.i_holes_x[h*COORD_W +: COORD_W];
        hole_y  = bus.i_holes_y[h*COORD_W +: COORD_W];
        hole_en = bus.i_hole_en[h];
      end
    end
  end

  hole_dist_sq #(
    .RADIUS (RADIUS),
    .IDX_W  (IDX_W)
  ) u_dist (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (flush),
    .i_vld   (issue_vld),
    .i_idx   (issue_idx),
    .i_en    (hole_en),
    .i_ax    (snap_x_q),
    .i_ay    (snap_y_q),
    .i_bx    (hole_x),
    .i_by    (hole_y),
    .o_vld   (res_vld),
    .o_idx   (res_idx),
    .o_hit   (res_hit)
  );

  // Results arrive in index order, so the first hit seen in a scan is the lowest index.
  always_comb begin
    scan_hit = best_vld_q | (res_vld & res_hit);
    scan_idx = best_vld_q ? best_idx_q : res_idx;
    dwell_nx = '0;
    cand_nx  = cand_q;
    if (scan_hit) begin
      if (scan_idx == cand_q) begin
        dwell_nx = (dwell_q == '1) ? dwell_q : dwell_q + DWELL_W'(1);
      end else begin
        cand_nx  = scan_idx;
        dwell_nx = DWELL_W'(1);
      end
    end
    goal_nx = (cand_nx == IDX_W'(GOAL_IDX));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dwell_d     = dwell_q;
    cand_d      = cand_q;
    best_vld_d  = best_vld_q;
    best_idx_d  = best_idx_q;
    fall_d      = fall_q;
    win_d       = win_q;
    hole_idx_d  = hole_idx_q;
    scan_done_d = 1'b0;
    issue_vld   = 1'b0;
    flush       = 1'b0;
    take_snap   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.is_game_playing) begin
          state_d    = SCAN;
          cnt_d      = '0;
          best_vld_d = 1'b0;
          take_snap  = 1'b1;
        end
        if (bus.i_clear) begin
          dwell_d = '0;
          cand_d  = '0;
        end
      end

      SCAN: begin
        if (!bus.is_game_playing) begin
          state_d    = IDLE;
          flush      = 1'b1;
          dwell_d    = '0;
          best_vld_d = 1'b0;
          if (bus.i_clear) cand_d = '0;
        end else if (cnt_q == LAST_CNT) begin
          scan_done_d = 1'b1;
          best_vld_d  = 1'b0;
          if (bus.i_clear) begin
            dwell_d   = '0;
            cand_d    = '0;
            cnt_d     = '0;
            take_snap = 1'b1;
          end else if (dwell_nx >= DWELL_W'(DWELL)) begin
            state_d    = CAPTURED;
            dwell_d    = dwell_nx;
            cand_d     = cand_nx;
            hole_idx_d = cand_nx;
            win_d      = goal_nx;
            fall_d     = ~goal_nx;
          end else begin
            dwell_d   = dwell_nx;
            cand_d    = cand_nx;
            cnt_d     = '0;
            take_snap = 1'b1;
          end
        end else begin
          issue_vld = (cnt_q < ISSUE_END);
          cnt_d     = cnt_q + CNT_W'(1);
          if (res_vld && res_hit && !best_vld_q) begin
            best_vld_d = 1'b1;
            best_idx_d = res_idx;
          end
          if (bus.i_clear) begin
            dwell_d = '0;
            cand_d  = '0;
          end
        end
      end

      CAPTURED: begin
        if (bus.i_clear) begin
          state_d    = IDLE;
          fall_d     = 1'b0;
          win_d      = 1'b0;
          hole_idx_d = '0;
          dwell_d    = '0;
          cand_d     = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    snap_x_d = take_snap ? bus.i_bl_x : snap_x_q;
    snap_y_d = take_snap ? bus.i_bl_y : snap_y_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      snap_x_q    <= '0;
      snap_y_q    <= '0;
      dwell_q     <= '0;
      cand_q      <= '0;
      best_vld_q  <= 1'b0;
      best_idx_q  <= '0;
      fall_q      <= 1'b0;
      win_q       <= 1'b0;
      hole_idx_q  <= '0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      snap_x_q    <= snap_x_d;
      snap_y_q    <= snap_y_d;
      dwell_q     <= dwell_d;
      cand_q      <= cand_d;
      best_vld_q  <= best_vld_d;
      best_idx_q  <= best_idx_d;
      fall_q      <= fall_d;
      win_q       <= win_d;
      hole_idx_q  <= hole_idx_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign bus.o_fall_in   = fall_q;
  assign bus.o_win       = win_q;
  assign bus.o_hole_idx  = hole_idx_q;
  assign bus.o_scan_done = scan_done_q;

endmodule
